// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM state encoding,
// default bus addresses (also used by the CPU address decoder) and status layout.
package uart_tx_pkg;

  localparam logic [7:0] DEFAULT_DATA_ADDR = 8'hF8;
  localparam logic [7:0] DEFAULT_STAT_ADDR = 8'hF9;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

  typedef struct packed {
    logic [4:0] rsvd;
    logic       overflow;
    logic       full;
    logic       busy;
  } uart_status_t;

  // Baud counter width: enough bits to hold CLKS_PER_BIT-1, never less than one.
  function automatic int baud_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small transmit FIFO with combinational head; accepts a push while full when a
// pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_FULL);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // When full with a concurrent pop, wr_ptr equals rd_ptr: the head is read
  // before the edge that overwrites it, so the ordering is safe.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: data/status registers on the CPU data bus,
// a transmit FIFO and a START/DATA/STOP serialiser with a registered tx line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  DATA_ADDR    = DEFAULT_DATA_ADDR,
  parameter logic [7:0]  STAT_ADDR    = DEFAULT_STAT_ADDR,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       tx
);

  localparam int               BAUD_W    = baud_width(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = (BAUD_W)'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = (BAUD_W)'(1);
  localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;

  uart_state_t       state_reg;
  uart_state_t       state_next;
  logic [BAUD_W-1:0] baud_reg;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx_reg;
  logic [2:0]        bit_idx_next;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_next;
  logic              tx_reg;
  logic              tx_next;
  logic              overflow_reg;
  logic              overflow_next;

  logic              data_hit;
  logic              stat_hit;
  logic              push;
  logic              pop;
  logic              baud_end;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  uart_status_t      status;

  assign data_hit = (addr == DATA_ADDR);
  assign stat_hit = (addr == STAT_ADDR);
  assign baud_end = (baud_reg == BAUD_LAST);

  // A store to a full FIFO is still taken when the serialiser frees a slot this cycle.
  assign push = we && data_hit && (!fifo_full || pop);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = ST_START;
          baud_next  = '0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          state_next   = ST_DATA;
          baud_next    = '0;
          bit_idx_next = 3'd0;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next   = ST_STOP;
            bit_idx_next = 3'd0;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next frame so queued bytes go out without a gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = fifo_head;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
      end
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      ST_START: tx_next = 1'b0;
      ST_DATA:  tx_next = shift_reg[bit_idx_reg];
      default:  tx_next = 1'b1;
    endcase
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (we && stat_hit) begin
      overflow_next = 1'b0;
    end else if (we && data_hit && !push) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      baud_reg     <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    status          = '0;
    status.overflow = overflow_reg;
    status.full     = fifo_full;
    status.busy     = (state_reg != ST_IDLE) || (fifo_count != '0);
  end

  assign out = stat_hit ? status : 8'h00;
  assign tx  = tx_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (4 clocks per bit, 4-deep FIFO): a serial monitor
// decodes every frame and compares it with bytes queued when stores were accepted.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [7:0] DATA_A = 8'hF8;
  localparam logic [7:0] STAT_A = 8'hF9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       tx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DATA_ADDR    (DATA_A),
    .STAT_ADDR    (STAT_A),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .addr  (addr),
    .in    (din),
    .out   (dout),
    .tx    (tx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One store sampled at the next rising edge; returns 1 time unit after it.
  task automatic store(input logic [7:0] a, input logic [7:0] d, input bit accept);
    we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    we = 1'b0; addr = 8'h00;
    $display("store addr=0x%02h data=0x%02h expect_accept=%0d cycle=%0d", a, d, accept, cyc);
    if (accept) exp_q.push_back(d);
  endtask

  task automatic read_now(input string tag, input logic [7:0] a, input logic [7:0] expv);
    addr = a; #1;
    $display("read  addr=0x%02h data=0x%02h expect=0x%02h (%s)", a, dout, expv, tag);
    check(tag, dout, expv);
    addr = 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    addr = STAT_A;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dout[0] === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    addr = 8'h00;
    check("idle_within_budget", done, 1);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic watch_quiet(input string tag, input int ncyc);
    int bad = 0;
    frame_starts.delete();
    repeat (ncyc) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check(tag, bad, 0);
    check({tag, "_frames"}, frame_starts.size(), 0);
  endtask

  // Serial monitor: samples every cycle of a frame at the falling edge.
  initial begin
    logic [9:0] bits;
    int         bad;
    int         start;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        start = cyc; bad = 0; aborted = 1'b0; bits = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int c = 0; c < CPB && !aborted; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
            else if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) bad++;
          end
        end
        if (!aborted) begin
          frame_starts.push_back(start);
          $display("frame start_cycle=%0d data=0x%02h stop=%0b", start, bits[8:1], bits[9]);
          check("frame_bits_stable", bad, 0);
          check("frame_stop_bit", bits[9], 1);
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("frame_data", bits[8:1], exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    logic e;
    logic [7:0] a5;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("reset_tx", tx, 1);
    read_now("reset_stat", STAT_A, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_now("idle_stat", STAT_A, 8'h00);

    // Single frame waveform, store at edge 0
    a5 = 8'hA5;
    store(DATA_A, a5, 1'b1);
    bad = 0;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      if (k < 2) e = 1'b1;
      else if (k < 6) e = 1'b0;
      else if (k < 38) e = a5[(k - 6) / CPB];
      else e = 1'b1;
      if (tx !== e) bad++;
    end
    check("a5_waveform_mismatches", bad, 0);
    @(negedge clk);
    read_now("a5_idle_after_frame", STAT_A, 8'h00);
    wait_idle(20);

    // Five back-to-back stores, frames without gaps
    frame_starts.delete();
    for (int i = 1; i <= 5; i++) store(DATA_A, 8'(i), 1'b1);
    read_now("burst_full_stat", STAT_A, 8'h03);
    wait_idle(5 * FRAME + 20);
    check("burst_frame_count", frame_starts.size(), 5);
    for (int i = 1; i < 5 && i < frame_starts.size(); i++)
      check("burst_frame_gap", frame_starts[i] - frame_starts[i-1], FRAME);
    read_now("burst_no_overflow", STAT_A, 8'h00);

    // Overflow: six stores while the first byte is in flight
    for (int i = 0; i < 6; i++) store(DATA_A, 8'h10 + 8'(i), i < 5);
    read_now("ovf_full_stat", STAT_A, 8'h07);
    repeat (42) @(posedge clk); #1;
    read_now("ovf_sticky_stat", STAT_A, 8'h05);
    store(STAT_A, 8'hFF, 1'b0);
    read_now("ovf_cleared_stat", STAT_A, 8'h01);
    wait_idle(6 * FRAME);
    read_now("ovf_idle_stat", STAT_A, 8'h00);

    // Store on the STOP-to-START pop edge with a full FIFO
    for (int i = 0; i < 5; i++) store(DATA_A, 8'hC0 + 8'(i), 1'b1);
    repeat (36) @(posedge clk); #1;
    read_now("popedge_before", STAT_A, 8'h03);
    store(DATA_A, 8'hC5, 1'b1);
    read_now("popedge_accepted", STAT_A, 8'h03);
    wait_idle(6 * FRAME + 20);
    read_now("popedge_idle_stat", STAT_A, 8'h00);

    // Foreign address decode
    store(DATA_A, 8'h3C, 1'b1);
    repeat (10) @(posedge clk); #1;
    read_now("foreign_read_in_frame", 8'h10, 8'h00);
    read_now("data_addr_read", DATA_A, 8'h00);
    read_now("stat_in_frame", STAT_A, 8'h01);
    wait_idle(2 * FRAME);
    store(8'h10, 8'h55, 1'b0);
    watch_quiet("foreign_store_no_frame", FRAME + 10);
    read_now("foreign_store_stat", STAT_A, 8'h00);

    // Asynchronous reset during data bit 3 of a 0x00 frame
    store(DATA_A, 8'h00, 1'b1);
    repeat (19) @(posedge clk); #2;
    check("pre_reset_tx_low", tx, 0);
    rst_n = 1'b0; #1;
    check("async_reset_tx", tx, 1);
    read_now("reset_mid_stat", STAT_A, 8'h00);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    watch_quiet("post_reset_quiet", FRAME + 10);
    read_now("post_reset_stat", STAT_A, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
